// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiters: FSM encoding,
// statistics counter width and the round-robin pick function.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    ACTIVE
  } arb_state_e;

  localparam int CNT_W  = 32;
  localparam int RR_MAX = 16;

  // First set bit of req searched upward from (last+1) mod n, with wrap.
  // The loop bound is fixed so it unrolls to a static priority network.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] req,
                                         input logic [3:0]        last,
                                         input int                n);
    logic [3:0] pick;
    int         idx;
    pick = '0;
    for (int off = RR_MAX; off > 0; off--) begin
      if (off <= n) begin
        idx = (int'(last) + off) % n;
        if (req[idx]) pick = 4'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin priority encoder: picks the first requester after
// i_last (with wrap) and flags whether any request is present.
module rr_select
  import axis_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [LW-1:0] i_last,
  output logic [LW-1:0] o_winner,
  output logic          o_any
);

  logic [RR_MAX-1:0] w_req;
  logic [3:0]        w_last;
  logic [3:0]        w_pick;

  assign w_req  = RR_MAX'(i_req);
  assign w_last = 4'(i_last);

  always_comb begin
    w_pick = rr_pick(w_req, w_last, N);
  end

  assign o_winner = LW'(w_pick);
  assign o_any    = |i_req;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin N:1 AXI-Stream arbiter; grant held from first
// beat to TLAST. Define PKT_ARB_STATS_EN to add per-input packet/bad counters.
module axis_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DW         = 512,
  parameter int IDW        = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_INPUTS*DW-1:0]   AXIS_IN_TDATA,
  input  logic [NUM_INPUTS*DW/8-1:0] AXIS_IN_TKEEP,
  input  logic [NUM_INPUTS-1:0]      AXIS_IN_TUSER,
  input  logic [NUM_INPUTS-1:0]      AXIS_IN_TLAST,
  input  logic [NUM_INPUTS-1:0]      AXIS_IN_TVALID,
  output logic [NUM_INPUTS-1:0]      AXIS_IN_TREADY,
  output logic [DW-1:0]              AXIS_OUT_TDATA,
  output logic [DW/8-1:0]            AXIS_OUT_TKEEP,
  output logic                       AXIS_OUT_TUSER,
  output logic                       AXIS_OUT_TLAST,
  output logic [IDW-1:0]             AXIS_OUT_TID,
  output logic                       AXIS_OUT_TVALID,
  input  logic                       AXIS_OUT_TREADY
`ifdef PKT_ARB_STATS_EN
  ,
  output logic [NUM_INPUTS*CNT_W-1:0] pkt_count,
  output logic [NUM_INPUTS*CNT_W-1:0] bad_count
`endif
);

  localparam int LW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int KW = DW / 8;
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_INPUTS - 1);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic [LW-1:0] r_grant;
  logic [LW-1:0] w_grant_nxt;
  logic [LW-1:0] r_last;
  logic [LW-1:0] w_last_nxt;
  logic [LW-1:0] w_winner;
  logic          w_any;
  logic          w_pkt_end;
  logic [31:0]   w_sel;

  rr_select #(
    .N  (NUM_INPUTS),
    .LW (LW)
  ) u_rr_select (
    .i_req    (AXIS_IN_TVALID),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= LAST_RST;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign w_pkt_end = (r_state == ACTIVE) && AXIS_IN_TVALID[r_grant] && AXIS_OUT_TREADY &&
                     AXIS_IN_TLAST[r_grant];

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_last_nxt      = r_last;
    AXIS_IN_TREADY  = '0;
    AXIS_OUT_TVALID = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_winner;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        AXIS_OUT_TVALID         = AXIS_IN_TVALID[r_grant];
        AXIS_IN_TREADY[r_grant] = AXIS_OUT_TREADY;
        if (w_pkt_end) begin
          w_state_nxt = IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath is a pure mux off the grant register, so no beat latency is added.
  assign w_sel          = 32'(r_grant);
  assign AXIS_OUT_TDATA = AXIS_IN_TDATA[w_sel*DW +: DW];
  assign AXIS_OUT_TKEEP = AXIS_IN_TKEEP[w_sel*KW +: KW];
  assign AXIS_OUT_TUSER = AXIS_IN_TUSER[r_grant];
  assign AXIS_OUT_TLAST = AXIS_IN_TLAST[r_grant];
  assign AXIS_OUT_TID   = IDW'(r_grant);

`ifdef PKT_ARB_STATS_EN
  logic [CNT_W-1:0] r_pkt_cnt [NUM_INPUTS];
  logic [CNT_W-1:0] r_bad_cnt [NUM_INPUTS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        r_pkt_cnt[i] <= '0;
        r_bad_cnt[i] <= '0;
      end
    end else if (w_pkt_end) begin
      r_pkt_cnt[r_grant] <= r_pkt_cnt[r_grant] + CNT_W'(1);
      if (AXIS_OUT_TUSER) r_bad_cnt[r_grant] <= r_bad_cnt[r_grant] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_stats
    assign pkt_count[g*CNT_W +: CNT_W] = r_pkt_cnt[g];
    assign bad_count[g*CNT_W +: CNT_W] = r_bad_cnt[g];
  end
`endif

endmodule
